// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply/divide unit for the execute stage.
// 32-step shift-add multiply or restoring divide; stalls execute while running.
module muldiv_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MulDivE,
    input  logic [1:0]      MulDivOpE,
    input  logic [XLEN-1:0] SrcA_E,
    input  logic [XLEN-1:0] SrcB_E,
    input  logic            FlushE,
    output logic            StallE,
    output logic            DoneE,
    output logic [XLEN-1:0] MulDivResultE,
    output logic            BusyE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   hi_q, lo_q, opnd_q;

    logic              start, div_zero, last_iter;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;

    assign start     = MulDivE & ~FlushE;
    assign div_zero  = MulDivOpE[1] & (SrcB_E == '0);
    assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

    // Multiply: {hi,lo} holds {partial product, remaining multiplier bits}.
    assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};

    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    // The remainder stays below the divisor, so the difference always fits XLEN bits.
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    assign div_diff  = div_shift[XLEN-1:0] - opnd_q;

    always_comb begin
        state_d = state_q;
        StallE  = 1'b0;
        DoneE   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    StallE  = 1'b1;
                    state_d = div_zero ? DONE : CALC;
                end
            end
            CALC: begin
                StallE = ~FlushE;
                if (last_iter) state_d = DONE;
            end
            DONE: begin
                DoneE   = ~FlushE;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (FlushE) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                op_q  <= MulDivOpE;
                cnt_q <= '0;
                if (!MulDivOpE[1]) begin
                    hi_q   <= '0;
                    lo_q   <= SrcB_E;
                    opnd_q <= SrcA_E;
                end else if (div_zero) begin
                    // Preload the architected divide-by-zero results.
                    hi_q   <= SrcA_E;
                    lo_q   <= '1;
                    opnd_q <= '0;
                end else begin
                    hi_q   <= '0;
                    lo_q   <= SrcA_E;
                    opnd_q <= SrcB_E;
                end
            end else if (state_q == CALC) begin
                cnt_q <= cnt_q + 1'b1;
                if (!op_q[1]) begin
                    hi_q <= mul_sum[XLEN:1];
                    lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
                end else begin
                    hi_q <= div_ge ? div_diff : div_shift[XLEN-1:0];
                    lo_q <= {lo_q[XLEN-2:0], div_ge};
                end
            end
        end
    end

    always_comb begin
        MulDivResultE = '0;
        if (state_q == DONE && !FlushE)
            MulDivResultE = op_q[0] ? hi_q : lo_q;
    end

    assign BusyE = (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        MulDivE;
    logic [1:0]  MulDivOpE;
    logic [31:0] SrcA_E, SrcB_E;
    logic        FlushE;
    logic        StallE, DoneE, BusyE;
    logic [31:0] MulDivResultE;

    int total = 0;
    int bad   = 0;

    muldiv_sequencer #(.XLEN(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .MulDivE(MulDivE), .MulDivOpE(MulDivOpE),
        .SrcA_E(SrcA_E), .SrcB_E(SrcB_E), .FlushE(FlushE), .StallE(StallE),
        .DoneE(DoneE), .MulDivResultE(MulDivResultE), .BusyE(BusyE)
    );

    always #5 clk = ~clk;

    // Issues one op at a negedge, holds it until DoneE, then drops MulDivE.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int nstall, output int dcyc,
                         output logic stall_at_done);
        logic seen;
        @(negedge clk);
        MulDivE = 1'b1; MulDivOpE = op; SrcA_E = a; SrcB_E = b;
        nstall = 0; dcyc = 0; seen = 1'b0; res = 'x; stall_at_done = 1'bx;
        for (int c = 1; c <= 60 && !seen; c++) begin
            #1;
            if (DoneE) begin
                seen = 1'b1; dcyc = c; res = MulDivResultE; stall_at_done = StallE;
            end else begin
                if (StallE) nstall++;
                @(negedge clk);
            end
        end
        @(negedge clk);
        MulDivE = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; MulDivE = 1'b0; MulDivOpE = 2'b00; SrcA_E = '0; SrcB_E = '0; FlushE = 1'b0;
        #2;
        total++; if (StallE !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", StallE); end
        total++; if (DoneE !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", DoneE); end
        total++; if (BusyE !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", BusyE); end
        total++; if (MulDivResultE !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", MulDivResultE); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul_basic;
        logic [31:0] r; int ns, dc; logic sd;
        do_op(2'b00, 32'd7, 32'd6, r, ns, dc, sd);
        total++; if (r !== 32'h2A) begin bad++; $display("FAIL mul7x6 got=%h exp=0000002a", r); end
        total++; if (ns != 33) begin bad++; $display("FAIL mul_stall_cycles got=%0d exp=33", ns); end
        total++; if (dc != 34) begin bad++; $display("FAIL mul_latency got=%0d exp=34", dc); end
        total++; if (sd !== 1'b0) begin bad++; $display("FAIL mul_stall_at_done got=%b exp=0", sd); end
        #1;
        total++; if (DoneE !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b exp=0", DoneE); end
        total++; if (BusyE !== 1'b0) begin bad++; $display("FAIL no_restart_busy got=%b exp=0", BusyE); end
        total++; if (MulDivResultE !== 32'h0) begin bad++; $display("FAIL result_zero_idle got=%h exp=0", MulDivResultE); end
    endtask

    task automatic test_mul_high;
        logic [31:0] r; int ns, dc; logic sd;
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, ns, dc, sd);
        total++; if (r !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mulhu_ff got=%h exp=fffffffe", r); end
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, ns, dc, sd);
        total++; if (r !== 32'h0000_0001) begin bad++; $display("FAIL mul_ff got=%h exp=00000001", r); end
        do_op(2'b01, 32'h0001_0000, 32'h0003_0000, r, ns, dc, sd);
        total++; if (r !== 32'h0000_0003) begin bad++; $display("FAIL mulhu_shift got=%h exp=00000003", r); end
    endtask

    task automatic test_div;
        logic [31:0] r; int ns, dc; logic sd;
        do_op(2'b10, 32'd100, 32'd7, r, ns, dc, sd);
        total++; if (r !== 32'd14) begin bad++; $display("FAIL divu_100_7 got=%0d exp=14", r); end
        total++; if (dc != 34) begin bad++; $display("FAIL div_latency got=%0d exp=34", dc); end
        do_op(2'b11, 32'd100, 32'd7, r, ns, dc, sd);
        total++; if (r !== 32'd2) begin bad++; $display("FAIL remu_100_7 got=%0d exp=2", r); end
        do_op(2'b10, 32'h8000_0000, 32'd1, r, ns, dc, sd);
        total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL divu_msb got=%h exp=80000000", r); end
        do_op(2'b11, 32'hFFFF_FFFF, 32'h0001_0000, r, ns, dc, sd);
        total++; if (r !== 32'h0000_FFFF) begin bad++; $display("FAIL remu_big got=%h exp=0000ffff", r); end
    endtask

    task automatic test_div_zero;
        logic [31:0] r; int ns, dc; logic sd;
        do_op(2'b10, 32'd55, 32'd0, r, ns, dc, sd);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu_zero got=%h exp=ffffffff", r); end
        total++; if (dc != 2) begin bad++; $display("FAIL divzero_latency got=%0d exp=2", dc); end
        total++; if (ns != 1) begin bad++; $display("FAIL divzero_stall got=%0d exp=1", ns); end
        do_op(2'b11, 32'h1234_5678, 32'd0, r, ns, dc, sd);
        total++; if (r !== 32'h1234_5678) begin bad++; $display("FAIL remu_zero got=%h exp=12345678", r); end
    endtask

    task automatic test_flush;
        logic [31:0] r; int ns, dc; logic sd;
        @(negedge clk);
        MulDivE = 1'b1; MulDivOpE = 2'b00; SrcA_E = 32'd9; SrcB_E = 32'd9;
        repeat (11) @(negedge clk);
        FlushE = 1'b1;
        #1;
        total++; if (StallE !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", StallE); end
        total++; if (BusyE !== 1'b1) begin bad++; $display("FAIL flush_busy_calc got=%b exp=1", BusyE); end
        @(negedge clk);
        FlushE = 1'b0; MulDivE = 1'b0;
        #1;
        total++; if (BusyE !== 1'b0) begin bad++; $display("FAIL flush_idle got=%b exp=0", BusyE); end
        total++; if (DoneE !== 1'b0 || StallE !== 1'b0) begin bad++; $display("FAIL flush_outputs done=%b stall=%b exp=0,0", DoneE, StallE); end
        do_op(2'b00, 32'd3, 32'd5, r, ns, dc, sd);
        total++; if (r !== 32'd15) begin bad++; $display("FAIL mul_after_flush got=%0d exp=15", r); end
        total++; if (dc != 34) begin bad++; $display("FAIL flush_mul_latency got=%0d exp=34", dc); end
        // Flush arriving in the DONE cycle must suppress DoneE.
        @(negedge clk);
        MulDivE = 1'b1; MulDivOpE = 2'b10; SrcA_E = 32'd4; SrcB_E = 32'd0;
        @(negedge clk);
        FlushE = 1'b1;
        #1;
        total++; if (DoneE !== 1'b0) begin bad++; $display("FAIL flush_in_done got=%b exp=0", DoneE); end
        @(negedge clk);
        FlushE = 1'b0; MulDivE = 1'b0;
    endtask

    task automatic test_reset_mid;
        int done_seen, busy_seen;
        @(negedge clk);
        MulDivE = 1'b1; MulDivOpE = 2'b10; SrcA_E = 32'd1000; SrcB_E = 32'd3;
        repeat (21) @(negedge clk);
        rst = 1'b0; MulDivE = 1'b0;
        #1;
        total++; if (StallE !== 1'b0 || DoneE !== 1'b0 || BusyE !== 1'b0 || MulDivResultE !== 32'h0) begin
            bad++; $display("FAIL reset_mid stall=%b done=%b busy=%b res=%h exp=all0", StallE, DoneE, BusyE, MulDivResultE);
        end
        @(negedge clk); rst = 1'b1;
        done_seen = 0; busy_seen = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (DoneE) done_seen++;
            if (BusyE) busy_seen++;
            @(negedge clk);
        end
        total++; if (done_seen != 0) begin bad++; $display("FAIL reset_no_done got=%0d exp=0", done_seen); end
        total++; if (busy_seen != 0) begin bad++; $display("FAIL reset_no_busy got=%0d exp=0", busy_seen); end
    endtask

    task automatic test_back_to_back;
        int cyc, d1, d2;
        logic [31:0] r1, r2;
        d1 = 0; d2 = 0; r1 = 'x; r2 = 'x; cyc = 0;
        @(negedge clk);
        MulDivE = 1'b1; MulDivOpE = 2'b00; SrcA_E = 32'd12; SrcB_E = 32'd11;
        for (int c = 0; c < 120 && d2 == 0; c++) begin
            cyc++;
            #1;
            if (DoneE) begin
                if (d1 == 0) begin d1 = cyc; r1 = MulDivResultE; end
                else begin d2 = cyc; r2 = MulDivResultE; end
            end
            @(negedge clk);
            if (d1 != 0 && d2 == 0) begin
                MulDivOpE = 2'b10; SrcA_E = 32'd1000; SrcB_E = 32'd9;
            end
        end
        MulDivE = 1'b0;
        total++; if (r1 !== 32'd132) begin bad++; $display("FAIL b2b_mul got=%0d exp=132", r1); end
        total++; if (r2 !== 32'd111) begin bad++; $display("FAIL b2b_divu got=%0d exp=111", r2); end
        total++; if (d1 != 34) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=34", d1); end
        total++; if (d2 - d1 != 34) begin bad++; $display("FAIL b2b_spacing got=%0d exp=34", d2 - d1); end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_mul_high();
        test_div();
        test_div_zero();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
